// File: rtl/packet_mux_pkg.sv
// packet_mux_pkg: shared types and sizes for the packet mux datapath.
//   DATA_W / EMPTY_W    : beat data width and empty-byte field width
//   PKT_FIFO_CNT_W      : default width of the store-and-forward FIFO drop counter
//   pkt_fifo_state_e    : write-side FSM states of pkt_sf_fifo
package packet_mux_pkg;

    localparam int DATA_W         = 64;
    localparam int EMPTY_W        = 3;
    localparam int PKT_FIFO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DROP
    } pkt_fifo_state_e;

endpackage

// File: rtl/pkt_fifo_ram.sv
// pkt_fifo_ram: simple dual-port beat storage, synchronous write and
// combinational read. No control logic lives here.
//   clk       : write clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write payload
//   raddr_i   : read address
//   rdata_o   : read payload (combinational from raddr_i)
module pkt_fifo_ram #(
    parameter int PAYLOAD_W = 70,
    parameter int DEPTH     = 512,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [PAYLOAD_W-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [PAYLOAD_W-1:0] rdata_o
);

    logic [PAYLOAD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pkt_sf_fifo.sv
// pkt_sf_fifo: store-and-forward packet FIFO. A packet becomes visible to the
// reader only once its eop beat is stored; truncated, headless and oversize
// packets are discarded by rewinding the working write pointer to the last
// committed position.
//
// Optional feature: define PKT_FIFO_DROP_ERR_EN to also discard packets whose
// eop beat carries w_error=1. Without it such packets are delivered with
// r_error=1 on the last beat.
//
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   w_data/w_sop/w_eop/w_empty/w_error, w_valid, w_ready : write beat + handshake
//   r_data/r_sop/r_eop/r_empty/r_error, r_valid, r_ready : show-ahead read beat + handshake
//   pkt_count                       : complete packets stored
//   drop_pulse                      : one-cycle pulse per discarded packet
//   drop_cnt                        : saturating count of discarded packets
module pkt_sf_fifo #(
    parameter int DATA_W    = packet_mux_pkg::DATA_W,
    parameter int DEPTH     = 512,
    parameter int EMP_W     = packet_mux_pkg::EMPTY_W,
    parameter int N_LATENCY = 3,
    parameter int CNT_W     = packet_mux_pkg::PKT_FIFO_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       w_data,
    input  logic                    w_sop,
    input  logic                    w_eop,
    input  logic [EMP_W-1:0]        w_empty,
    input  logic                    w_error,
    input  logic                    w_valid,
    output logic                    w_ready,
    output logic [DATA_W-1:0]       r_data,
    output logic                    r_sop,
    output logic                    r_eop,
    output logic [EMP_W-1:0]        r_empty,
    output logic                    r_error,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        drop_cnt
);

    import packet_mux_pkg::*;

    localparam int AW        = $clog2(DEPTH);
    localparam int PW        = AW + 1;
    localparam int PAYLOAD_W = DATA_W + EMP_W + 3;
    localparam logic [PW-1:0] LIMIT = PW'(DEPTH - N_LATENCY);
    localparam logic [PW-1:0] ONE   = PW'(1);

    // Elaboration-time parameter check.
    if (DEPTH <= N_LATENCY || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $fatal(1, "pkt_sf_fifo: DEPTH must be a power of two greater than N_LATENCY");
    end

    pkt_fifo_state_e state_q, state_d;
    logic [PW-1:0]   w_ptr_q, w_ptr_d;
    logic [PW-1:0]   w_cmt_q, w_cmt_d;
    logic [PW-1:0]   r_ptr_q, r_ptr_d;
    logic [PW-1:0]   pkt_count_q, pkt_count_d;
    logic            drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]   used;
    logic [PW-1:0]   base;
    logic            from_idle;
    logic            w_acc, r_acc, commit, err_drop;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [PAYLOAD_W-1:0] rd_payload;

`ifdef PKT_FIFO_DROP_ERR_EN
    assign err_drop = w_error;
`else
    assign err_drop = 1'b0;
`endif

    assign used    = w_ptr_q - r_ptr_q;
    assign w_ready = (state_q == DROP) || (used < LIMIT);
    assign w_acc   = w_valid && w_ready;
    assign r_valid = (pkt_count_q != '0);
    assign r_acc   = r_valid && r_ready;

    // Write-side FSM. A restart (sop inside a packet) rewinds and then handles
    // the new beat exactly as if it had arrived in IDLE, all in one cycle.
    always_comb begin
        state_d      = state_q;
        w_ptr_d      = w_ptr_q;
        w_cmt_d      = w_cmt_q;
        drop_pulse_d = 1'b0;
        commit       = 1'b0;
        mem_we       = 1'b0;
        base         = w_ptr_q;
        from_idle    = (state_q == IDLE);
        mem_waddr    = w_ptr_q[AW-1:0];

        if (state_q == DROP) begin
            if (w_acc && w_eop) begin
                drop_pulse_d = 1'b1;
                state_d      = IDLE;
            end
        end else begin
            if (state_q == IN_PKT && w_acc && w_sop) begin
                drop_pulse_d = 1'b1;
                base         = w_cmt_q;
                w_ptr_d      = w_cmt_q;
                from_idle    = 1'b1;
                state_d      = IDLE;
            end
            mem_waddr = base[AW-1:0];

            if (w_acc) begin
                if (from_idle) begin
                    if (!w_sop) begin
                        // headless beat: discard until the next eop
                        drop_pulse_d = w_eop;
                        state_d      = w_eop ? IDLE : DROP;
                    end else if (w_eop) begin
                        if (err_drop) begin
                            drop_pulse_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            mem_we  = 1'b1;
                            w_ptr_d = base + ONE;
                            w_cmt_d = base + ONE;
                            commit  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        mem_we  = 1'b1;
                        w_ptr_d = base + ONE;
                        state_d = IN_PKT;
                    end
                end else if (w_eop && err_drop) begin
                    drop_pulse_d = 1'b1;
                    w_ptr_d      = w_cmt_q;
                    state_d      = IDLE;
                end else begin
                    mem_we  = 1'b1;
                    w_ptr_d = w_ptr_q + ONE;
                    if (w_eop) begin
                        w_cmt_d = w_ptr_q + ONE;
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end else if (state_q == IN_PKT && pkt_count_q == '0 && used >= LIMIT) begin
                // Packet larger than the storage: nothing readable will ever
                // free space, so abandon it and swallow the rest.
                w_ptr_d = w_cmt_q;
                state_d = DROP;
            end
        end
    end

    always_comb begin
        r_ptr_d     = r_acc ? r_ptr_q + ONE : r_ptr_q;
        pkt_count_d = pkt_count_q;
        case ({commit, r_acc && r_eop})
            2'b10:   pkt_count_d = pkt_count_q + ONE;
            2'b01:   pkt_count_d = pkt_count_q - ONE;
            default: pkt_count_d = pkt_count_q;
        endcase
        drop_cnt_d = drop_cnt_q;
        if (drop_pulse_q && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            w_ptr_q      <= '0;
            w_cmt_q      <= '0;
            r_ptr_q      <= '0;
            pkt_count_q  <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            w_ptr_q      <= w_ptr_d;
            w_cmt_q      <= w_cmt_d;
            r_ptr_q      <= r_ptr_d;
            pkt_count_q  <= pkt_count_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    pkt_fifo_ram #(
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i ({w_error, w_empty, w_eop, w_sop, w_data}),
        .raddr_i (r_ptr_q[AW-1:0]),
        .rdata_o (rd_payload)
    );

    assign {r_error, r_empty, r_eop, r_sop, r_data} = rd_payload;
    assign pkt_count  = pkt_count_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pkt_sf_fifo.sv
module tb_pkt_sf_fifo;

    localparam int DEPTH = 16;
    localparam int NLAT  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] w_data = '0;
    logic        w_sop = 1'b0, w_eop = 1'b0, w_error = 1'b0, w_valid = 1'b0;
    logic [2:0]  w_empty = '0;
    logic        w_ready;
    logic [63:0] r_data;
    logic        r_sop, r_eop, r_error, r_valid;
    logic [2:0]  r_empty;
    logic        r_ready = 1'b0;
    logic [4:0]  pkt_count;
    logic        drop_pulse;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_drop = 0;
    logic [69:0] exp_q[$];

    always #5 clk = ~clk;

    pkt_sf_fifo #(
        .DATA_W(64), .DEPTH(DEPTH), .EMP_W(3), .N_LATENCY(NLAT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .w_data(w_data), .w_sop(w_sop), .w_eop(w_eop), .w_empty(w_empty),
        .w_error(w_error), .w_valid(w_valid), .w_ready(w_ready),
        .r_data(r_data), .r_sop(r_sop), .r_eop(r_eop), .r_empty(r_empty),
        .r_error(r_error), .r_valid(r_valid), .r_ready(r_ready),
        .pkt_count(pkt_count), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [69:0] mk(logic [63:0] d, logic s, logic e, logic er, logic [2:0] emp);
        return {er, emp, e, s, d};
    endfunction

    // Drive one beat, waiting (bounded) for w_ready; no checking here.
    task automatic send(input logic [63:0] d, input logic s, input logic e,
                        input logic er, input logic [2:0] emp);
        for (int i = 0; i < 50 && !w_ready; i++) tick();
        w_data = d; w_sop = s; w_eop = e; w_error = er; w_empty = emp; w_valid = 1'b1;
        tick();
        w_valid = 1'b0; w_sop = 1'b0; w_eop = 1'b0; w_error = 1'b0;
    endtask

    task automatic send_exp(input logic [63:0] d, input logic s, input logic e,
                            input logic er, input logic [2:0] emp);
        exp_q.push_back(mk(d, s, e, er, emp));
        send(d, s, e, er, emp);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        n_cmp++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
        n_cmp++; if (w_ready !== 1'b1) begin n_err++; $display("FAIL reset_w_ready: got %b want 1", w_ready); end
        n_cmp++; if (drop_pulse !== 1'b0 || drop_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_drop: got pulse=%b cnt=%0d want 0/0", drop_pulse, drop_cnt); end
    endtask

    task automatic test_three_beat();
        logic [69:0] got;
        r_ready = 1'b0;
        send_exp(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        n_cmp++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL three_rv_b0: got %b want 0", r_valid); end
        send_exp(rnd64(), 1'b0, 1'b0, 1'b0, 3'd0);
        n_cmp++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL three_rv_b1: got %b want 0", r_valid); end
        send_exp(rnd64(), 1'b0, 1'b1, 1'b0, 3'd5);
        n_cmp++; if (r_valid !== 1'b1 || pkt_count !== 5'd1) begin
            n_err++; $display("FAIL three_commit: got rv=%b cnt=%0d want 1/1", r_valid, pkt_count); end
        for (int i = 0; i < 20 && r_valid; i++) begin
            got = {r_error, r_empty, r_eop, r_sop, r_data};
            r_ready = 1'b1; tick(); r_ready = 1'b0;
            n_cmp++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
                n_err++; $display("FAIL three_data: got %h want %h", got, (exp_q.size() != 0) ? exp_q[0] : 70'h0); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_cmp++; if (pkt_count !== 5'd0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL three_drained: got cnt=%0d left=%0d want 0/0", pkt_count, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [69:0] got;
        logic [63:0] d2;
        send_exp(rnd64(), 1'b1, 1'b1, 1'b0, 3'd1);
        d2 = rnd64();
        exp_q.push_back(mk(d2, 1'b1, 1'b1, 1'b0, 3'd2));
        // second commit and read of the first packet in the same cycle
        got = {r_error, r_empty, r_eop, r_sop, r_data};
        w_data = d2; w_sop = 1'b1; w_eop = 1'b1; w_empty = 3'd2; w_valid = 1'b1; r_ready = 1'b1;
        tick();
        w_valid = 1'b0; w_sop = 1'b0; w_eop = 1'b0; r_ready = 1'b0;
        n_cmp++; if (got !== exp_q[0]) begin n_err++; $display("FAIL b2b_first: got %h want %h", got, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++; if (pkt_count !== 5'd1) begin n_err++; $display("FAIL b2b_count: got %0d want 1", pkt_count); end
        n_cmp++; if (r_data !== d2) begin n_err++; $display("FAIL b2b_show_ahead: got %h want %h", r_data, d2); end
        for (int i = 0; i < 20 && r_valid; i++) begin
            got = {r_error, r_empty, r_eop, r_sop, r_data};
            r_ready = 1'b1; tick(); r_ready = 1'b0;
            n_cmp++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
                n_err++; $display("FAIL b2b_drain: got %h", got); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_truncation();
        logic [69:0] got;
        send(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        send(rnd64(), 1'b0, 1'b0, 1'b0, 3'd0);
        send_exp(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        exp_drop++;
        n_cmp++; if (drop_pulse !== 1'b1) begin n_err++; $display("FAIL trunc_pulse: got %b want 1", drop_pulse); end
        send_exp(rnd64(), 1'b0, 1'b0, 1'b0, 3'd0);
        n_cmp++; if (drop_pulse !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
            n_err++; $display("FAIL trunc_cnt: got pulse=%b cnt=%0d want 0/%0d", drop_pulse, drop_cnt, exp_drop); end
        n_cmp++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL trunc_rv: got %b want 0", r_valid); end
        send_exp(rnd64(), 1'b0, 1'b1, 1'b0, 3'd7);
        for (int i = 0; i < 20 && r_valid; i++) begin
            got = {r_error, r_empty, r_eop, r_sop, r_data};
            r_ready = 1'b1; tick(); r_ready = 1'b0;
            n_cmp++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
                n_err++; $display("FAIL trunc_data: got %h", got); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL trunc_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_stray_beat();
        send(rnd64(), 1'b0, 1'b1, 1'b0, 3'd0);
        exp_drop++;
        n_cmp++; if (drop_pulse !== 1'b1 || r_valid !== 1'b0) begin
            n_err++; $display("FAIL stray: got pulse=%b rv=%b want 1/0", drop_pulse, r_valid); end
        tick();
        n_cmp++; if (drop_cnt !== 16'(exp_drop)) begin
            n_err++; $display("FAIL stray_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_overflow();
        int waits, total_waits, wait_idx;
        logic saw_rv;
        total_waits = 0; wait_idx = -1; saw_rv = 1'b0;
        r_ready = 1'b0;
        for (int b = 0; b < 20; b++) begin
            waits = 0;
            while (!w_ready && waits < 20) begin
                tick(); waits++;
                if (r_valid) saw_rv = 1'b1;
            end
            if (waits != 0 && wait_idx < 0) wait_idx = b;
            total_waits += waits;
            w_data = rnd64(); w_sop = (b == 0); w_eop = (b == 19); w_valid = 1'b1;
            tick();
            w_valid = 1'b0; w_sop = 1'b0; w_eop = 1'b0;
            if (r_valid) saw_rv = 1'b1;
        end
        exp_drop++;
        n_cmp++; if (total_waits != 1 || wait_idx != 13) begin
            n_err++; $display("FAIL ovf_ready: got waits=%0d at beat %0d want 1 at 13", total_waits, wait_idx); end
        n_cmp++; if (drop_pulse !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", drop_pulse); end
        tick();
        n_cmp++; if (drop_cnt !== 16'(exp_drop) || pkt_count !== 5'd0) begin
            n_err++; $display("FAIL ovf_cnt: got drop=%0d pkts=%0d want %0d/0", drop_cnt, pkt_count, exp_drop); end
        n_cmp++; if (saw_rv !== 1'b0 || w_ready !== 1'b1) begin
            n_err++; $display("FAIL ovf_rv: got rv_seen=%b w_ready=%b want 0/1", saw_rv, w_ready); end
    endtask

    task automatic test_error_pkt();
        logic [69:0] got;
`ifdef PKT_FIFO_DROP_ERR_EN
        send(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        send(rnd64(), 1'b0, 1'b0, 1'b0, 3'd0);
        send(rnd64(), 1'b0, 1'b1, 1'b1, 3'd3);
        exp_drop++;
        n_cmp++; if (drop_pulse !== 1'b1 || r_valid !== 1'b0) begin
            n_err++; $display("FAIL err_drop: got pulse=%b rv=%b want 1/0", drop_pulse, r_valid); end
        tick();
        n_cmp++; if (drop_cnt !== 16'(exp_drop) || r_valid !== 1'b0) begin
            n_err++; $display("FAIL err_cnt: got %0d rv=%b want %0d/0", drop_cnt, r_valid, exp_drop); end
`else
        send_exp(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        send_exp(rnd64(), 1'b0, 1'b0, 1'b0, 3'd0);
        send_exp(rnd64(), 1'b0, 1'b1, 1'b1, 3'd3);
        n_cmp++; if (r_valid !== 1'b1 || drop_pulse !== 1'b0) begin
            n_err++; $display("FAIL err_keep: got rv=%b pulse=%b want 1/0", r_valid, drop_pulse); end
        for (int i = 0; i < 20 && r_valid; i++) begin
            got = {r_error, r_empty, r_eop, r_sop, r_data};
            r_ready = 1'b1; tick(); r_ready = 1'b0;
            n_cmp++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
                n_err++; $display("FAIL err_data: got %h", got); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_cmp++; if (exp_q.size() != 0 || drop_cnt !== 16'(exp_drop)) begin
            n_err++; $display("FAIL err_left: got left=%0d drop=%0d want 0/%0d", exp_q.size(), drop_cnt, exp_drop); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [69:0] got;
        send_exp(rnd64(), 1'b1, 1'b1, 1'b0, 3'd0);
        send_exp(rnd64(), 1'b1, 1'b1, 1'b0, 3'd0);
        send(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        send(rnd64(), 1'b0, 1'b0, 1'b0, 3'd0);
        n_cmp++; if (pkt_count !== 5'd2) begin n_err++; $display("FAIL rmid_pre: got %0d want 2", pkt_count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        n_cmp++; if (pkt_count !== 5'd0 || r_valid !== 1'b0 || w_ready !== 1'b1) begin
            n_err++; $display("FAIL rmid_clear: got cnt=%0d rv=%b wr=%b want 0/0/1", pkt_count, r_valid, w_ready); end
        n_cmp++; if (drop_pulse !== 1'b0 || drop_cnt !== 16'd0) begin
            n_err++; $display("FAIL rmid_drop: got pulse=%b cnt=%0d want 0/0", drop_pulse, drop_cnt); end
        send_exp(rnd64(), 1'b1, 1'b0, 1'b0, 3'd0);
        send_exp(rnd64(), 1'b0, 1'b1, 1'b0, 3'd4);
        n_cmp++; if (pkt_count !== 5'd1) begin n_err++; $display("FAIL rmid_post: got %0d want 1", pkt_count); end
        for (int i = 0; i < 20 && r_valid; i++) begin
            got = {r_error, r_empty, r_eop, r_sop, r_data};
            r_ready = 1'b1; tick(); r_ready = 1'b0;
            n_cmp++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
                n_err++; $display("FAIL rmid_data: got %h", got); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        n_cmp++; if (exp_q.size() != 0 || pkt_count !== 5'd0) begin
            n_err++; $display("FAIL rmid_left: got left=%0d cnt=%0d want 0/0", exp_q.size(), pkt_count); end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_back_to_back();
        test_truncation();
        test_stray_beat();
        test_overflow();
        test_error_pkt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_sf_fifo.md
# pkt_sf_fifo

Store-and-forward packet FIFO for the packet mux datapath, the next generation of the plain word FIFO. It buffers whole Avalon-ST-style packets (sop/eop/empty/error) and presents a packet to the reader only after its eop beat has been written. It discards malformed packets, and packets that cannot fit, by rewinding the write pointer. It sits between each ingress port and the mux arbiter, so the arbiter never stalls mid-packet on an underrunning source.

## Interface
- DATA_W, packet_mux_pkg::DATA_W (64): data beat width
- DEPTH, 512: beats of storage, power of two, > N_LATENCY
- EMP_W, packet_mux_pkg::EMPTY_W (3): empty-byte field width
- N_LATENCY, 3: writer backpressure reaction latency; w_ready deasserts at DEPTH-N_LATENCY used beats
- CNT_W, 16: width of saturating drop counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- w_data/w_sop/w_eop/w_empty/w_error  in  DATA_W/1/1/EMP_W/1  write beat
- w_valid  in  1; w_ready  out  1  write handshake
- r_data/r_sop/r_eop/r_empty/r_error  out  DATA_W/1/1/EMP_W/1  read beat
- r_valid  out  1; r_ready  in  1  read handshake
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored
- drop_pulse  out  1  one-cycle pulse per discarded packet
- drop_cnt  out  CNT_W  saturating count of discarded packets

## Operation
- Write accept: w_valid && w_ready. Read accept: r_valid && r_ready.
- Pointers, each $clog2(DEPTH)+1 bits wide with a wrap bit:
  - w_ptr: working write pointer.
  - w_ptr_cmt: committed write pointer.
  - r_ptr: read pointer.
- used = w_ptr - r_ptr (modular).
- Write FSM, state in {IDLE, IN_PKT, DROP}:
  - IDLE + accepted beat with sop&eop: write the beat, commit (w_ptr_cmt <= w_ptr+1), stay in IDLE.
  - IDLE + accepted beat with sop only: write the beat, go to IN_PKT.
  - IDLE + beat without sop: discard it, go to DROP. If that beat has eop, stay in IDLE and pulse drop_pulse.
  - IN_PKT + eop: write the beat, commit, go to IDLE.
  - IN_PKT + sop (truncated packet): rewind w_ptr to w_ptr_cmt, pulse drop_pulse, then restart the new beat as from IDLE in the same cycle.
  - IN_PKT, overflow: if pkt_count==0 and no commit is pending and used reaches DEPTH-N_LATENCY, rewind w_ptr to w_ptr_cmt and go to DROP.
  - DROP: w_ready forced to 1. All beats are discarded (no memory write). On the eop beat, pulse drop_pulse and go to IDLE.
- Only beats between w_ptr_cmt and r_ptr are readable. r_valid = (pkt_count != 0).
- Read outputs are show-ahead, driven combinationally from mem[r_ptr]. r_ptr advances on read accept.
- pkt_count: +1 on commit, -1 on a read accept with r_eop. A simultaneous +1/-1 nets to no change.
- Once r_valid rises, it stays high through the whole packet, because the entire packet is stored.
- w_ready = (state==DROP) || (used < DEPTH-N_LATENCY).
- drop_cnt increments on each drop_pulse and saturates at all-ones.

## Timing
- Reset values:
  - All pointers 0, state IDLE, pkt_count 0.
  - r_valid 0, drop_pulse 0, drop_cnt 0.
  - w_ready 1.
  - r_* data outputs undefined; they reflect mem content.
- Commit-to-read latency: 1 cycle. The eop is written at edge N; r_valid is high after edge N if the FIFO was empty.
- drop_pulse is asserted in the cycle after the discarding beat is accepted.
- A rewind takes effect at the same edge that accepts the triggering beat. Beats already committed are never disturbed.
- Pointer wrap is natural modular arithmetic. used == DEPTH is never reached, because w_ready is low from DEPTH-N_LATENCY.
- Reset asserted mid-packet: all state is cleared immediately. Partial and committed packets are lost, and no drop_pulse is issued.

## Configuration
- PKT_FIFO_DROP_ERR_EN defined: an eop beat with w_error=1 causes a rewind to w_ptr_cmt and a drop_pulse, and the packet is never visible to the reader.
- Undefined: errored packets are committed normally, with r_error=1 on their eop beat.

## Structure
- packet_mux_pkg additions:
  - typedef enum pkt_fifo_state_e {IDLE, IN_PKT, DROP}.
  - localparam PKT_FIFO_CNT_W = 16.
- One sub-module, pkt_fifo_ram: simple dual-port memory with a synchronous write and a combinational (asynchronous) read, PAYLOAD_W = DATA_W+EMP_W+3. It holds no control logic.
- The non-synthesis initial check $fatal-s if DEPTH <= N_LATENCY or DEPTH is not a power of two.

## Test plan
- 3-beat packet (sop, -, eop) with r_ready=0: r_valid stays 0 until the cycle after eop, then goes 1 with pkt_count=1. Draining gives 3 beats in order, then pkt_count=0.
- Two 1-beat packets (sop&eop) back to back, with a read of the first packet's beat in the same cycle as the second commit: pkt_count stays 1, and r_data equals the second payload.
- sop, data, then sop again (truncation): the first packet is never read, drop_pulse=1 once, drop_cnt=1, and the second packet is delivered intact.
- DEPTH=16, N_LATENCY=3, 20-beat packet, r_ready=0: w_ready is low for 1 cycle at used=13, then held at 1 through eop. drop_cnt=1, pkt_count=0, r_valid never asserted.
- Packet with w_error=1 on eop: with PKT_FIFO_DROP_ERR_EN it is dropped (drop_cnt=1, r_valid=0). Without the macro it is delivered with r_error=1 on the last beat.
- Assert rst_n=0 for 1 cycle after 2 packets are committed and 1 is in progress: next cycle pkt_count=0, r_valid=0, w_ready=1. A following packet passes normally.
